// File: rtl/mult_acc_rc.sv
// Stallable complex-by-real multiplier with optional per-packet accumulation,
// round-half-up shift and per-component saturation to a narrow output.
module mult_acc_rc #(
    parameter int WIDTH_REAL = 25,
    parameter int WIDTH_CPLX = 18,
    parameter int WIDTH_ACC  = 48,
    parameter int WIDTH_OUT  = 24,
    parameter int SHIFT      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    acc_en,
    input  logic                    clear_ovf,
    input  logic [WIDTH_REAL-1:0]   real_tdata,
    input  logic                    real_tlast,
    input  logic                    real_tvalid,
    output logic                    real_tready,
    input  logic [2*WIDTH_CPLX-1:0] cplx_tdata,
    input  logic                    cplx_tlast,
    input  logic                    cplx_tvalid,
    output logic                    cplx_tready,
    output logic [2*WIDTH_OUT-1:0]  p_tdata,
    output logic                    p_tlast,
    output logic                    p_tvalid,
    input  logic                    p_tready,
    output logic                    ovf_sticky
);

    localparam int PW     = WIDTH_REAL + WIDTH_CPLX;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [WIDTH_ACC:0] RND =
        (SHIFT > 0) ? ((WIDTH_ACC+1)'(1) <<< RND_SH) : '0;

    // Returns {saturated, value}; one guard bit keeps the rounding add exact.
    function automatic logic [WIDTH_OUT:0] round_sat(input logic signed [WIDTH_ACC-1:0] acc);
        logic signed [WIDTH_ACC:0] x;
        x = ($signed({acc[WIDTH_ACC-1], acc}) + RND) >>> SHIFT;
        if ((&x[WIDTH_ACC:WIDTH_OUT-1]) | ~(|x[WIDTH_ACC:WIDTH_OUT-1]))
            return {1'b0, x[WIDTH_OUT-1:0]};
        else
            return {1'b1, x[WIDTH_ACC], {(WIDTH_OUT-1){~x[WIDTH_ACC]}}};
    endfunction

    logic                          first_beat_q, first_beat_d, mode_q, mode_d;
    logic                          s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic                          s1_mode_q, s1_mode_d, s1_first_q, s1_first_d;
    logic signed [WIDTH_REAL-1:0]  s1_real_q, s1_real_d;
    logic signed [WIDTH_CPLX-1:0]  s1_i_q, s1_i_d, s1_q_q, s1_q_d;
    logic                          s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic                          s2_mode_q, s2_mode_d, s2_first_q, s2_first_d;
    logic signed [WIDTH_ACC-1:0]   s2_i_q, s2_i_d, s2_q_q, s2_q_d;
    logic                          s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
    logic signed [WIDTH_ACC-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic                          p_tvalid_q, p_tvalid_d, p_tlast_q, p_tlast_d;
    logic [WIDTH_OUT-1:0]          p_i_q, p_i_d, p_q_q, p_q_d;
    logic                          ovf_q, ovf_d;

    logic                          adv, accept, beat_mode;
    logic signed [PW-1:0]          mul_i, mul_q;
    logic [WIDTH_OUT:0]            rs_i, rs_q;
    logic                          unused_cplx_tlast;

    assign unused_cplx_tlast = cplx_tlast;

    // The whole pipeline advances together; only the output register can stall it.
    assign adv         = ~p_tvalid_q | p_tready;
    assign real_tready = cplx_tvalid & adv;
    assign cplx_tready = real_tvalid & adv;
    assign accept      = real_tvalid & cplx_tvalid & adv;
    assign beat_mode   = first_beat_q ? acc_en : mode_q;

    assign mul_i = PW'(s1_real_q) * PW'(s1_i_q);
    assign mul_q = PW'(s1_real_q) * PW'(s1_q_q);
    assign rs_i  = round_sat(acc_i_q);
    assign rs_q  = round_sat(acc_q_q);

    always_comb begin
        first_beat_d = first_beat_q;
        mode_d       = mode_q;
        s1_valid_d   = s1_valid_q;
        s1_last_d    = s1_last_q;
        s1_mode_d    = s1_mode_q;
        s1_first_d   = s1_first_q;
        s1_real_d    = s1_real_q;
        s1_i_d       = s1_i_q;
        s1_q_d       = s1_q_q;
        s2_valid_d   = s2_valid_q;
        s2_last_d    = s2_last_q;
        s2_mode_d    = s2_mode_q;
        s2_first_d   = s2_first_q;
        s2_i_d       = s2_i_q;
        s2_q_d       = s2_q_q;
        s3_valid_d   = s3_valid_q;
        s3_last_d    = s3_last_q;
        acc_i_d      = acc_i_q;
        acc_q_d      = acc_q_q;
        p_tvalid_d   = p_tvalid_q;
        p_tlast_d    = p_tlast_q;
        p_i_d        = p_i_q;
        p_q_d        = p_q_q;
        ovf_d        = ovf_q;

        if (accept) begin
            first_beat_d = real_tlast;
            mode_d       = beat_mode;
        end

        if (adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_last_d  = real_tlast;
                s1_mode_d  = beat_mode;
                s1_first_d = first_beat_q;
                s1_real_d  = real_tdata;
                s1_i_d     = cplx_tdata[2*WIDTH_CPLX-1:WIDTH_CPLX];
                s1_q_d     = cplx_tdata[WIDTH_CPLX-1:0];
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_last_d  = s1_last_q;
                s2_mode_d  = s1_mode_q;
                s2_first_d = s1_first_q;
                s2_i_d     = WIDTH_ACC'(mul_i);
                s2_q_d     = WIDTH_ACC'(mul_q);
            end

            // Accumulate mode emits only the packet total on its last beat.
            s3_valid_d = s2_valid_q & (~s2_mode_q | s2_last_q);
            if (s2_valid_q) begin
                s3_last_d = s2_last_q;
                if (s2_mode_q & ~s2_first_q) begin
                    acc_i_d = acc_i_q + s2_i_q;
                    acc_q_d = acc_q_q + s2_q_q;
                end else begin
                    acc_i_d = s2_i_q;
                    acc_q_d = s2_q_q;
                end
            end

            p_tvalid_d = s3_valid_q;
            if (s3_valid_q) begin
                p_tlast_d = s3_last_q;
                p_i_d     = rs_i[WIDTH_OUT-1:0];
                p_q_d     = rs_q[WIDTH_OUT-1:0];
            end
        end

        if (clear_ovf)
            ovf_d = 1'b0;
        if (adv & s3_valid_q & (rs_i[WIDTH_OUT] | rs_q[WIDTH_OUT]))
            ovf_d = 1'b1;
    end

    // NOTE: every state element uses <= so all stages sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_beat_q <= 1'b1;
            mode_q       <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_real_q    <= '0;
            s1_i_q       <= '0;
            s1_q_q       <= '0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_mode_q    <= 1'b0;
            s2_first_q   <= 1'b0;
            s2_i_q       <= '0;
            s2_q_q       <= '0;
            s3_valid_q   <= 1'b0;
            s3_last_q    <= 1'b0;
            acc_i_q      <= '0;
            acc_q_q      <= '0;
            p_tvalid_q   <= 1'b0;
            p_tlast_q    <= 1'b0;
            p_i_q        <= '0;
            p_q_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            first_beat_q <= first_beat_d;
            mode_q       <= mode_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_mode_q    <= s1_mode_d;
            s1_first_q   <= s1_first_d;
            s1_real_q    <= s1_real_d;
            s1_i_q       <= s1_i_d;
            s1_q_q       <= s1_q_d;
            s2_valid_q   <= s2_valid_d;
            s2_last_q    <= s2_last_d;
            s2_mode_q    <= s2_mode_d;
            s2_first_q   <= s2_first_d;
            s2_i_q       <= s2_i_d;
            s2_q_q       <= s2_q_d;
            s3_valid_q   <= s3_valid_d;
            s3_last_q    <= s3_last_d;
            acc_i_q      <= acc_i_d;
            acc_q_q      <= acc_q_d;
            p_tvalid_q   <= p_tvalid_d;
            p_tlast_q    <= p_tlast_d;
            p_i_q        <= p_i_d;
            p_q_q        <= p_q_d;
            ovf_q        <= ovf_d;
        end
    end

    assign p_tdata    = {p_i_q, p_q_q};
    assign p_tlast    = p_tlast_q;
    assign p_tvalid   = p_tvalid_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: doc/mult_acc_rc.md
# mult_acc_rc

Pipelined complex-by-real multiply with an optional per-packet accumulate mode, round/shift and saturation to a narrow output. It is the next-generation replacement for the shared-handshake I/Q mult-add pair in the RFNoC DSP library. It performs a true AXI-Stream join of the real and complex inputs and a fully stallable pipeline. It sits after coefficient/sample sources in correlators, window-and-sum, and FIR-tap blocks.

## Interface
- WIDTH_REAL, 25, signed real operand width.
- WIDTH_CPLX, 18, signed width of each I/Q component.
- WIDTH_ACC, 48, signed accumulator width; must be ≥ WIDTH_REAL+WIDTH_CPLX.
- WIDTH_OUT, 24, signed width of each output I/Q component.
- SHIFT, 0, arithmetic right shift applied before rounding (0..WIDTH_ACC-WIDTH_OUT).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- acc_en  in  1  mode select; 1 = accumulate over packet, 0 = per-beat product. Sampled on the first beat of each packet.
- clear_ovf  in  1  synchronous clear of ovf_sticky.
- real_tdata  in  WIDTH_REAL  real operand.
- real_tlast  in  1  packet delimiter; the only tlast used.
- real_tvalid  in  1  real input valid.
- real_tready  out  1  real input ready.
- cplx_tdata  in  2*WIDTH_CPLX  {I, Q}, I in the upper half.
- cplx_tlast  in  1  ignored.
- cplx_tvalid  in  1  complex input valid.
- cplx_tready  out  1  complex input ready.
- p_tdata  out  2*WIDTH_OUT  {I, Q}, I in the upper half.
- p_tlast  out  1  output packet delimiter.
- p_tvalid  out  1  output valid.
- p_tready  in  1  output ready.
- ovf_sticky  out  1  set on any output saturation.

## Operation
- Join:
  - adv = ~p_tvalid | p_tready (global pipeline enable).
  - real_tready = cplx_tvalid & adv; cplx_tready = real_tvalid & adv.
  - A beat is accepted when both valids are high and adv is 1.
  - Neither ready depends on its own valid.
- Pipeline, four stages, all gated by adv; each stage carries valid, last and mode bits:
  - S1 registers the joined operands.
  - S2 computes full-precision signed products I·r and Q·r (WIDTH_REAL+WIDTH_CPLX bits), sign-extended to WIDTH_ACC.
  - S3 is the accumulator.
  - S4 does round/saturate.
- first_beat flag:
  - Set by reset and after any accepted beat with real_tlast=1.
  - Cleared by any other accepted beat.
  - acc_en is latched into the packet mode when an accepted beat has first_beat=1.
- Mode 0 (pass):
  - S3 loads the product.
  - S3 is valid for every beat; last = beat's real_tlast.
- Mode 1 (accumulate):
  - On a packet's first beat, S3 loads the product; otherwise S3 adds the product.
  - S3 presents a valid only on the tlast beat, with last=1.
  - Non-last beats produce no output.
- Accumulator overflow: wraps two's-complement and is not detected.
- S4 computation:
  - x = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, i.e. round half up.
  - Saturate to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1], per component.
- ovf_sticky:
  - Set in the cycle S4 loads a saturated component.
  - clear_ovf clears it; a simultaneous set wins.

## Timing
- Reset values: p_tvalid=0, p_tdata=0, p_tlast=0, ovf_sticky=0; all stage valids 0; accumulator 0; first_beat=1.
- The ready outputs remain combinational during reset (adv=1).
- Latency: a beat accepted at edge N appears on p_* after edge N+3.
  - In mode 1, this is measured from the tlast beat.
- Throughput: 1 beat/clock with p_tready held high.
- Stall:
  - p_tready=0 with p_tvalid=1 freezes all stages and drops both readies next combinational evaluation.
  - No data loss or duplication.
  - p_tdata/p_tlast are held stable while p_tvalid=1 and p_tready=0.
- Bubbles:
  - Stage valids propagate independently, so an empty S4 accepts while upstream fills.
  - adv depends only on the S4 state.
- Mode change mid-packet: ignored until the next first beat.
- Reset mid-packet: the partial accumulation is discarded. The next accepted beat is treated as a packet start.
- Back-to-back packets in mode 1: the new packet's first beat loads rather than adds, with no idle cycle required.

## Test plan
- Pass mode, SHIFT=0, WIDTH_OUT=24.
  - Stimulus: real=2, cplx=(3,-4), tlast=1, single beat accepted at edge N.
  - Required: p_tdata=(6,-8), p_tlast=1, p_tvalid high after edge N+3.
- Accumulate mode.
  - Stimulus: 4-beat packet, real=1,2,3,4, cplx=(1,-1) each.
  - Required: exactly one output (10,-10), p_tlast=1. An immediately following 2-beat packet real=5,5 yields (10,-10), proving the load-not-add restart.
- Backpressure.
  - Stimulus: continuous 32-beat ramp, p_tready low for 10 cycles mid-stream.
  - Required: all 32 products in order with none lost or repeated; readies low while stalled; p_tdata stable.
- Join skew.
  - Stimulus: real_tvalid constant 1, cplx_tvalid toggling every cycle.
  - Required: beats accepted only when cplx_tvalid=1; real_tready follows cplx_tvalid; outputs pair the correct operands.
- Rounding/saturation.
  - SHIFT=2: product I=6 → 2 and I=-6 → -1.
  - SHIFT=0, WIDTH_OUT=16: real=2^20, I=2^10 → I=32767 and ovf_sticky=1; clear_ovf → ovf_sticky=0.
- Reset mid-packet.
  - Stimulus: mode 1, 2 of 4 beats accepted, then reset pulse, then a 1-beat packet real=7, cplx=(1,0).
  - Required: output (7,0); no stale sum.
